// File: rtl/avalon_dp_ram_ctrl.sv
// rtl/avalon_dp_ram_ctrl.sv - dual-port Avalon-MM RAM with byte enables, clken stall and clear engine
module avalon_dp_ram_ctrl #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_clken,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_read,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  input  logic                    clear_req,
  output logic                    clear_busy
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    s1_acc, s1_wr, s1_rd;
  logic [READ_LATENCY-1:0] s1_vld_q, s2_vld_q;
  logic [DATA_WIDTH-1:0]   s1_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   s2_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   s1_hold_q, s2_hold_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (&clr_addr_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state_q is a flop, so waitrequest is registered without an extra stage
  assign clear_busy     = (state_q == CLEAR);
  assign s1_waitrequest = clear_busy;

  assign s1_acc = s1_chipselect & s1_clken & (s1_read | s1_write) & ~s1_waitrequest;
  assign s1_wr  = s1_acc & s1_write;
  assign s1_rd  = s1_acc & s1_read & ~s1_write;

  // No reset: array contents survive reset; reads below see the pre-write word
  always_ff @(posedge clk_clk) begin
    if (clear_busy) begin
      mem[clr_addr_q] <= CLEAR_VALUE;
    end else if (s1_wr) begin
      for (int b = 0; b < BE_W; b++)
        if (s1_byteenable[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_vld_q  <= '0;
      s2_vld_q  <= '0;
      s1_hold_q <= '0;
      s2_hold_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        s1_dat_q[i] <= '0;
        s2_dat_q[i] <= '0;
      end
    end else begin
      // s1 pipeline freezes as a whole while clken is low
      if (s1_clken) begin
        s1_vld_q[0] <= s1_rd;
        s1_dat_q[0] <= mem[s1_address];
        for (int i = 1; i < READ_LATENCY; i++) begin
          s1_vld_q[i] <= s1_vld_q[i-1];
          s1_dat_q[i] <= s1_dat_q[i-1];
        end
      end
      if (s1_readdatavalid) s1_hold_q <= s1_dat_q[READ_LATENCY-1];

      s2_vld_q[0] <= s2_read;
      s2_dat_q[0] <= mem[s2_address];
      for (int i = 1; i < READ_LATENCY; i++) begin
        s2_vld_q[i] <= s2_vld_q[i-1];
        s2_dat_q[i] <= s2_dat_q[i-1];
      end
      if (s2_readdatavalid) s2_hold_q <= s2_dat_q[READ_LATENCY-1];
    end
  end

  assign s1_readdatavalid = s1_vld_q[READ_LATENCY-1] & s1_clken;
  assign s1_readdata      = s1_readdatavalid ? s1_dat_q[READ_LATENCY-1] : s1_hold_q;
  assign s2_readdatavalid = s2_vld_q[READ_LATENCY-1];
  assign s2_readdata      = s2_readdatavalid ? s2_dat_q[READ_LATENCY-1] : s2_hold_q;

endmodule

// File: tb/tb_avalon_dp_ram_ctrl.sv
// tb/tb_avalon_dp_ram_ctrl.sv - scoreboard bench driving latency-1 and latency-2 instances in lockstep
module tb_avalon_dp_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [3:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_clken, s1_read, s1_write, s2_read, clear_req;
  logic [15:0] s1_writedata;
  logic [1:0]  s1_byteenable;

  logic [15:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;
  logic        a_wait, a_busy, b_wait, b_busy;

  always #5 clk = ~clk;

  avalon_dp_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1),
                       .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'hA5A5)) u1 (
    .clk_clk(clk), .reset_reset(reset_reset),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_clken(s1_clken),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_byteenable(s1_byteenable), .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v),
    .s1_waitrequest(a_wait), .s2_address(s2_address), .s2_read(s2_read),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v), .clear_req(clear_req),
    .clear_busy(a_busy));

  avalon_dp_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2),
                       .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'hA5A5)) u2 (
    .clk_clk(clk), .reset_reset(reset_reset),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_clken(s1_clken),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_byteenable(s1_byteenable), .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v),
    .s1_waitrequest(b_wait), .s2_address(s2_address), .s2_read(s2_read),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v), .clear_req(clear_req),
    .clear_busy(b_busy));

  typedef struct {
    logic [15:0] d;
    int          cyc;
    bit          exact;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int p, input logic [15:0] d, input bit exact);
    exp_t e;
    e.d = d; e.cyc = cyc; e.exact = exact;
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int p);
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Monitor: ports 0/1 = u1 s1/s2 (latency 1), ports 2/3 = u2 s1/s2 (latency 2)
  always @(negedge clk) begin
    logic [3:0]  vld;
    logic [15:0] dat [4];
    vld = {b_s2_v, b_s1_v, a_s2_v, a_s1_v};
    dat[0] = a_s1_rd; dat[1] = a_s2_rd; dat[2] = b_s1_rd; dat[3] = b_s2_rd;
    for (int p = 0; p < 4; p++) begin
      if (vld[p]) begin
        if (q_size(p) == 0) begin
          chk($sformatf("unexpected_valid_p%0d", p), 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   lat;
          e   = q_pop(p);
          lat = cyc - e.cyc;
          chk($sformatf("rdata_p%0d", p), dat[p], e.d);
          if (e.exact) chk($sformatf("latency_p%0d", p), lat, (p < 2) ? 1 : 2);
          else         chk($sformatf("stall_latency_p%0d", p), lat > ((p < 2) ? 1 : 2), 1);
          if (p == 0 || p == 2) chk($sformatf("valid_with_clken_p%0d", p), s1_clken, 1'b1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s1_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a; s1_writedata = d; s1_byteenable = be;
    tick();
    s1_chipselect = 1'b0; s1_write = 1'b0;
  endtask

  task automatic s1_rd(input logic [3:0] a, input logic [15:0] exp);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
    push_exp(0, exp, 1'b1);
    push_exp(2, exp, 1'b1);
    tick();
    s1_chipselect = 1'b0; s1_read = 1'b0;
  endtask

  task automatic s2_issue(input logic [3:0] a, input logic [15:0] exp);
    s2_read = 1'b1; s2_address = a;
    push_exp(1, exp, 1'b1);
    push_exp(3, exp, 1'b1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!a_busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    reset_reset = 1'b1; s1_address = '0; s2_address = '0; s1_chipselect = 1'b0;
    s1_clken = 1'b1; s1_read = 1'b0; s1_write = 1'b0; s2_read = 1'b0;
    s1_writedata = '0; s1_byteenable = 2'b11; clear_req = 1'b0;
    tick(); tick();

    @(negedge clk);
    chk("rst_s1_readdata", a_s1_rd, 16'h0000);
    chk("rst_s2_readdata", a_s2_rd, 16'h0000);
    chk("rst_valids", {a_s1_v, a_s2_v, b_s1_v, b_s2_v}, 4'b0000);
    chk("rst_busy_wait", {a_busy, a_wait, b_busy, b_wait}, 4'b1111);

    tick();
    reset_reset = 1'b0;
    count_busy(n);
    chk("por_clear_cycles", n, 16);
    chk("por_wait_low", a_wait, 1'b0);
    tick();

    for (int a = 0; a < 16; a++) s1_rd(4'(a), 16'hA5A5);
    repeat (3) tick();

    s1_wr(4'd3, 16'h1234, 2'b11);
    s1_wr(4'd3, 16'hFFFF, 2'b01);
    s1_rd(4'd3, 16'h12FF);
    repeat (3) tick();

    // clken stall: held result must appear only once clken is back
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 4'd3;
    push_exp(0, 16'h12FF, 1'b0);
    push_exp(2, 16'h12FF, 1'b0);
    tick();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_valid", {a_s1_v, b_s1_v}, 2'b00);
      tick();
    end
    s1_clken = 1'b1;
    repeat (4) tick();

    // read-before-write collision
    s1_wr(4'd5, 16'h0001, 2'b11);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd5; s1_writedata = 16'h0002;
    s1_byteenable = 2'b11;
    s2_issue(4'd5, 16'h0001);
    tick();
    s1_write = 1'b0; s1_chipselect = 1'b0;
    s2_issue(4'd5, 16'h0002);
    s1_rd(4'd5, 16'h0002);
    s2_read = 1'b0;
    repeat (3) tick();

    // clear request during operation
    s1_wr(4'd9, 16'h1111, 2'b11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!a_busy) break;
      if (k == 0) chk("clear_wait_high", a_wait, 1'b1);
      if (k < 3) begin
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd9; s1_writedata = 16'h2222;
      end
      if (k == 0) s2_issue(4'd3, 16'h12FF);
      if (k == 2) s2_issue(4'd9, 16'h1111);
      if (k == 5) clear_req = 1'b1;
      @(posedge clk); #1;
      s1_chipselect = 1'b0; s1_write = 1'b0; s2_read = 1'b0; clear_req = 1'b0;
      k++;
    end
    chk("req_clear_cycles", k, 16);
    tick();
    s1_rd(4'd9, 16'hA5A5);
    s1_rd(4'd3, 16'hA5A5);
    s1_rd(4'd5, 16'hA5A5);
    repeat (3) tick();

    // reset while the clear engine is at address 7
    s1_wr(4'd2, 16'h0BAD, 2'b11);
    s1_wr(4'd12, 16'h0C0C, 2'b11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("busy_at_addr7", a_busy, 1'b1);
    @(posedge clk); #1;
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    count_busy(n);
    chk("reset_restart_cycles", n, 16);
    tick();
    for (int a = 0; a < 16; a++) s1_rd(4'(a), 16'hA5A5);
    repeat (5) tick();

    chk("scoreboard_drained", q_size(0) + q_size(1) + q_size(2) + q_size(3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
